// File: rtl/fifo_param_sync.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a selectable standard or fall-through read port.
module fifo_param_sync #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int FWFT      = 0,
   parameter int AF_THRESH = 6,
   parameter int AE_THRESH = 1
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     wr_en_i,
   input  logic                     rd_en_i,
   input  logic                     clr_flags_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     dout_valid_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     almost_full_o,
   output logic                     almost_empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   output logic                     underflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      count_nxt;
   logic             wr_acc;
   logic             rd_acc;

   assign wr_acc = wr_en_i & ~full_o;
   assign rd_acc = rd_en_i & ~empty_o;

   always_comb begin
      count_nxt = count_o;
      if (wr_acc && !rd_acc)
         count_nxt = count_o + ONE_C;
      else if (rd_acc && !wr_acc)
         count_nxt = count_o - ONE_C;
   end

   // Status flags are registered off the next count so they line up with count_o.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count_o        <= '0;
         full_o         <= 1'b0;
         empty_o        <= 1'b1;
         almost_full_o  <= 1'b0;
         almost_empty_o <= 1'b1;
         overflow_o     <= 1'b0;
         underflow_o    <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + ONE_C;
         if (rd_acc)
            rd_ptr <= rd_ptr + ONE_C;
         count_o        <= count_nxt;
         full_o         <= (count_nxt == DEPTH_C);
         empty_o        <= (count_nxt == '0);
         almost_full_o  <= (count_nxt >= AF_C);
         almost_empty_o <= (count_nxt <= AE_C);
         if (wr_en_i && full_o)
            overflow_o <= 1'b1;
         else if (clr_flags_i)
            overflow_o <= 1'b0;
         if (rd_en_i && empty_o)
            underflow_o <= 1'b1;
         else if (clr_flags_i)
            underflow_o <= 1'b0;
      end
   end

   // Storage is never cleared; reset only blocks the write in its own cycle.
   always_ff @(posedge clk_i) begin
      if (reset_n_i && wr_acc)
         mem[wr_ptr[AW-1:0]] <= din_i;
   end

   generate
      if (FWFT == 0) begin : g_std
         logic [WIDTH-1:0] dout_q;
         logic             vld_q;

         always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
               dout_q <= '0;
               vld_q  <= 1'b0;
            end else begin
               vld_q <= rd_acc;
               if (rd_acc)
                  dout_q <= mem[rd_ptr[AW-1:0]];
            end
         end

         assign dout_o       = dout_q;
         assign dout_valid_o = vld_q;
      end else begin : g_fwft
         // Head word shown directly; zeroed while empty so stale storage never leaks out.
         assign dout_o       = empty_o ? '0 : mem[rd_ptr[AW-1:0]];
         assign dout_valid_o = ~empty_o;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_param_sync.sv
// Bench for fifo_param_sync: standard-mode instance driven from a vector table and a
// queue scoreboard, plus a fall-through instance exercised by a short hand sequence.
module tb_fifo_param_sync;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] din = 8'h00;
   logic       wr_en = 1'b0, rd_en = 1'b0, clr_flags = 1'b0;
   logic [7:0] dout;
   logic       dout_valid, full, empty, af, ae, ovf, udf;
   logic [3:0] count;

   logic [7:0] f_din = 8'h00;
   logic       f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
   logic [7:0] f_dout;
   logic       f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [3:0] f_count;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb[$];
   logic [7:0] m_dout = 8'h00;
   logic       m_vld = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

   typedef struct {
      logic       wr, rd, clr;
      logic [7:0] din;
      int         cnt;
      logic       ovf, udf;
   } vec_t;
   vec_t tbl[22];

   always #5 clk = ~clk;

   fifo_param_sync #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) u_std (
      .clk_i(clk), .reset_n_i(reset_n), .din_i(din), .wr_en_i(wr_en), .rd_en_i(rd_en),
      .clr_flags_i(clr_flags), .dout_o(dout), .dout_valid_o(dout_valid), .full_o(full),
      .empty_o(empty), .almost_full_o(af), .almost_empty_o(ae), .count_o(count),
      .overflow_o(ovf), .underflow_o(udf)
   );

   fifo_param_sync #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) u_fw (
      .clk_i(clk), .reset_n_i(reset_n), .din_i(f_din), .wr_en_i(f_wr), .rd_en_i(f_rd),
      .clr_flags_i(f_clr), .dout_o(f_dout), .dout_valid_o(f_vld), .full_o(f_full),
      .empty_o(f_empty), .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_count),
      .overflow_o(f_ovf), .underflow_o(f_udf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_std();
      int n;
      n = sb.size();
      chk("count", 32'(count), 32'(n));
      chk("full", 32'(full), 32'(n == 8));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_full", 32'(af), 32'(n >= 6));
      chk("almost_empty", 32'(ae), 32'(n <= 1));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("underflow", 32'(udf), 32'(m_udf));
      chk("dout_valid", 32'(dout_valid), 32'(m_vld));
      chk("dout", 32'(dout), 32'(m_dout));
   endtask

   // One clock of stimulus on the standard instance; the queue predicts the read data.
   task automatic cyc(input logic w, input logic r, input logic clr, input logic [7:0] d);
      logic wa, ra, was_full, was_empty;
      was_full  = (sb.size() == 8);
      was_empty = (sb.size() == 0);
      wa = w && !was_full;
      ra = r && !was_empty;
      wr_en = w; rd_en = r; clr_flags = clr; din = d;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0;
      m_ovf = (w && was_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = (r && was_empty) ? 1'b1 : (clr ? 1'b0 : m_udf);
      if (ra) m_dout = sb.pop_front();
      if (wa) sb.push_back(d);
      m_vld = ra;
      check_std();
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0; wr_en = 1'b1; din = 8'h99;
      repeat (n) @(posedge clk);
      #1;
      sb.delete();
      m_dout = 8'h00; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      check_std();
      reset_n = 1'b1; wr_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++)
         tbl[i] = '{1'b1, 1'b0, 1'b0, 8'h10 + 8'(i), i + 1, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'hAA, 8, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 8'hAB, 8, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++)
         tbl[12+i] = '{1'b0, 1'b1, 1'b0, 8'h00, 7 - i, 1'b0, 1'b0};
      tbl[20] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
      tbl[21] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0};

      // Reset with a pending write: nothing is stored
      do_reset(2);
      chk("fw_rst_count", 32'(f_count), 32'd0);
      chk("fw_rst_empty", 32'(f_empty), 32'd1);
      chk("fw_rst_valid", 32'(f_vld), 32'd0);
      chk("fw_rst_dout", 32'(f_dout), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);

      // Fill, overflow, clear, drain, underflow
      for (int i = 0; i < 22; i++) begin
         cyc(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
         chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
         chk("tbl_overflow", 32'(ovf), 32'(tbl[i].ovf));
         chk("tbl_underflow", 32'(udf), 32'(tbl[i].udf));
      end
      chk("drain_last", 32'(dout), 32'h17);

      // Simultaneous read/write at count 4, pointers wrap past 2*DEPTH
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 8'h40 + 8'(i));
         chk("simul_count", 32'(count), 32'd4);
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("simul_tail", 32'(dout), 32'h53);

      // Mid-operation reset discards contents
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
      do_reset(1);
      chk("midrst_count", 32'(count), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 8'h77);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("midrst_data", 32'(dout), 32'h77);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);

      // Fall-through instance
      f_wr = 1'b1; f_din = 8'h55;
      @(posedge clk); #1; f_wr = 1'b0;
      chk("fw_valid_after_wr", 32'(f_vld), 32'd1);
      chk("fw_dout_after_wr", 32'(f_dout), 32'h55);
      chk("fw_empty_after_wr", 32'(f_empty), 32'd0);
      @(posedge clk); #1;
      chk("fw_hold_valid", 32'(f_vld), 32'd1);
      chk("fw_hold_dout", 32'(f_dout), 32'h55);
      f_wr = 1'b1; f_din = 8'h66;
      @(posedge clk); #1; f_wr = 1'b0;
      chk("fw_count2", 32'(f_count), 32'd2);
      chk("fw_head_kept", 32'(f_dout), 32'h55);
      f_rd = 1'b1;
      @(posedge clk); #1;
      chk("fw_pop1_dout", 32'(f_dout), 32'h66);
      chk("fw_pop1_count", 32'(f_count), 32'd1);
      @(posedge clk); #1;
      chk("fw_pop2_empty", 32'(f_empty), 32'd1);
      chk("fw_pop2_valid", 32'(f_vld), 32'd0);
      chk("fw_udf_clear", 32'(f_udf), 32'd0);
      @(posedge clk); #1; f_rd = 1'b0;
      chk("fw_underflow", 32'(f_udf), 32'd1);
      chk("fw_count_empty", 32'(f_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
